// File: rtl/ld_to_affine.sv
// Lopez-Dahab projective (X,Y,Z) to affine (x,y) over GF(2^4).
// Z^-1 = Z^14 via one shared multiplier plus combinational squarers.
module ld_to_affine #(
    parameter int         W    = 4,
    parameter logic [W:0] POLY = 5'b10011
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] X_in,
    input  logic [W-1:0] Y_in,
    input  logic [W-1:0] Z_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic         inf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INV1,
        S_INV2,
        S_MULX,
        S_MULY,
        S_DONE
    } state_t;

    // Full carry-less product, then fold the high bits back with POLY.
    function automatic logic [W-1:0] gf_mul(
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [2*W-2:0] p;
        p = '0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) p = p ^ ({{(W-1){1'b0}}, a} << i);
        end
        for (int i = 2*W-2; i >= W; i--) begin
            if (p[i]) p = p ^ ({{(W-2){1'b0}}, POLY} << (i-W));
        end
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] gf_sq(input logic [W-1:0] a);
        return gf_mul(a, a);
    endfunction

    state_t       r_state;
    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic [W-1:0] r_z;
    logic [W-1:0] r_t;
    logic [W-1:0] r_zi;
    logic [W-1:0] r_xr;
    logic [W-1:0] r_yr;
    logic [W-1:0] r_xo;
    logic [W-1:0] r_yo;
    logic         r_inf;
    logic         r_busy;
    logic         r_done;

    logic [W-1:0] w_z2;
    logic [W-1:0] w_z4;
    logic [W-1:0] w_z8;
    logic [W-1:0] w_zi2;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_p;

    assign w_z2  = gf_sq(r_z);
    assign w_z4  = gf_sq(w_z2);
    assign w_z8  = gf_sq(w_z4);
    assign w_zi2 = gf_sq(r_zi);

    // Operand steering for the single shared multiplier.
    always_comb begin
        w_a = '0;
        w_b = '0;
        case (r_state)
            S_INV1: begin
                w_a = w_z2;
                w_b = w_z4;
            end
            S_INV2: begin
                w_a = r_t;
                w_b = w_z8;
            end
            S_MULX: begin
                w_a = r_x;
                w_b = r_zi;
            end
            S_MULY: begin
                w_a = r_y;
                w_b = w_zi2;
            end
            default: begin
                w_a = '0;
                w_b = '0;
            end
        endcase
    end

    assign w_p = gf_mul(w_a, w_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_t     <= '0;
            r_zi    <= '0;
            r_xr    <= '0;
            r_yr    <= '0;
            r_xo    <= '0;
            r_yo    <= '0;
            r_inf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x     <= X_in;
                        r_y     <= Y_in;
                        r_z     <= Z_in;
                        r_busy  <= 1'b1;
                        r_state <= S_INV1;
                    end
                end
                S_INV1: begin
                    r_t     <= w_p;
                    r_state <= S_INV2;
                end
                S_INV2: begin
                    r_zi    <= w_p;
                    r_state <= S_MULX;
                end
                S_MULX: begin
                    r_xr    <= w_p;
                    r_state <= S_MULY;
                end
                S_MULY: begin
                    r_yr    <= w_p;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_xo    <= r_xr;
                    r_yo    <= r_yr;
                    r_inf   <= (r_z == '0);
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign x_out = r_xo;
    assign y_out = r_yo;
    assign inf   = r_inf;

endmodule
